// File: rtl/hardwired_sequencer.sv
// ============================================================================
// Module   : hardwired_sequencer
// Purpose  : Timing-state control unit for the 16-bit accumulator CPU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hardwired_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] ir,
   input  logic [DATA_WIDTH-1:0] ac,
   input  logic [DATA_WIDTH-1:0] dr,
   output logic [5:0]            ld,
   output logic [5:0]            inc,
   output logic [5:0]            clr,
   output logic [7:0]            x,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [1:0]            alu_op,
   output logic                  halted,
   output logic [3:0]            sc
);

   localparam int c_AR = 0;
   localparam int c_PC = 1;
   localparam int c_DR = 2;
   localparam int c_AC = 3;
   localparam int c_IR = 4;
   localparam int c_TR = 5;
   localparam logic [5:0] c_RESET_CLR = 6'b001010;

   localparam int c_X_AR  = 1;
   localparam int c_X_PC  = 2;
   localparam int c_X_DR  = 3;
   localparam int c_X_AC  = 4;
   localparam int c_X_IR  = 5;
   localparam int c_X_MEM = 7;

   typedef enum logic [3:0] {
      T0 = 4'd0,
      T1 = 4'd1,
      T2 = 4'd2,
      T3 = 4'd3,
      T4 = 4'd4,
      T5 = 4'd5,
      T6 = 4'd6
   } t_state;

   t_state r_sc, w_sc_next;
   logic   r_i, w_i_next;
   logic   r_s, w_s_next;

   logic [5:0] w_ld, w_inc, w_clr;
   logic [7:0] w_x;
   logic       w_rd, w_wr;
   logic [1:0] w_alu;
   logic [2:0] w_d;
   logic       w_skip;
   logic       w_unused;

   assign w_d      = ir[ADDR_WIDTH+2:ADDR_WIDTH];
   assign w_unused = &{1'b0, ir[ADDR_WIDTH-2:8], ir[6:5], ir[1]};
   // Skip tests look at AC as it stands in T3, before CLA/INC land.
   assign w_skip   = (ir[4] & ~ac[DATA_WIDTH-1]) |
                     (ir[3] &  ac[DATA_WIDTH-1]) |
                     (ir[2] & (ac == '0));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sc <= T0;
         r_i  <= 1'b0;
         r_s  <= 1'b1;
      end else if (!r_s) begin
         r_sc <= T0;
         if (start) begin
            r_s <= 1'b1;
         end
      end else begin
         r_sc <= w_sc_next;
         r_i  <= w_i_next;
         r_s  <= w_s_next;
      end
   end

   always_comb begin
      w_ld      = '0;
      w_inc     = '0;
      w_clr     = '0;
      w_x       = '0;
      w_rd      = 1'b0;
      w_wr      = 1'b0;
      w_alu     = 2'b00;
      w_sc_next = T0;
      w_i_next  = r_i;
      w_s_next  = r_s;
      if (r_s) begin
         case (r_sc)
            T0: begin
               w_x[c_X_PC] = 1'b1;
               w_ld[c_AR]  = 1'b1;
               w_sc_next   = T1;
            end
            T1: begin
               w_rd         = 1'b1;
               w_x[c_X_MEM] = 1'b1;
               w_ld[c_IR]   = 1'b1;
               w_inc[c_PC]  = 1'b1;
               w_sc_next    = T2;
            end
            T2: begin
               w_x[c_X_IR] = 1'b1;
               w_ld[c_AR]  = 1'b1;
               w_i_next    = ir[DATA_WIDTH-1];
               w_sc_next   = T3;
            end
            T3: begin
               if (w_d == 3'd7) begin
                  if (!r_i) begin
                     w_clr[c_AC] = ir[11];
                     w_inc[c_AC] = ir[7] & ~ir[11];
                     w_inc[c_PC] = w_skip;
                     if (ir[0]) begin
                        w_s_next = 1'b0;
                     end
                  end
                  w_sc_next = T0;
               end else begin
                  if (r_i) begin
                     w_rd         = 1'b1;
                     w_x[c_X_MEM] = 1'b1;
                     w_ld[c_AR]   = 1'b1;
                  end
                  w_sc_next = T4;
               end
            end
            T4: begin
               case (w_d)
                  3'd0, 3'd1, 3'd2, 3'd6: begin
                     w_rd         = 1'b1;
                     w_x[c_X_MEM] = 1'b1;
                     w_ld[c_DR]   = 1'b1;
                     w_sc_next    = T5;
                  end
                  3'd3: begin
                     w_x[c_X_AC] = 1'b1;
                     w_wr        = 1'b1;
                  end
                  3'd4: begin
                     w_x[c_X_AR] = 1'b1;
                     w_ld[c_PC]  = 1'b1;
                  end
                  3'd5: begin
                     w_x[c_X_PC] = 1'b1;
                     w_wr        = 1'b1;
                     w_inc[c_AR] = 1'b1;
                     w_sc_next   = T5;
                  end
                  default: w_sc_next = T0;
               endcase
            end
            T5: begin
               case (w_d)
                  3'd0: begin
                     w_ld[c_AC] = 1'b1;
                     w_alu      = 2'b01;
                  end
                  3'd1: begin
                     w_ld[c_AC] = 1'b1;
                     w_alu      = 2'b10;
                  end
                  3'd2: begin
                     w_ld[c_AC] = 1'b1;
                     w_alu      = 2'b00;
                  end
                  3'd5: begin
                     w_x[c_X_AR] = 1'b1;
                     w_ld[c_PC]  = 1'b1;
                  end
                  3'd6: begin
                     w_inc[c_DR] = 1'b1;
                     w_sc_next   = T6;
                  end
                  default: w_sc_next = T0;
               endcase
            end
            T6: begin
               if (w_d == 3'd6) begin
                  w_x[c_X_DR] = 1'b1;
                  w_wr        = 1'b1;
                  w_inc[c_PC] = (dr == '0);
               end
            end
            default: w_sc_next = T0;
         endcase
      end
      // TR is never driven by this instruction set but keeps its slot.
      w_ld[c_TR] = 1'b0;
   end

   assign ld        = reset ? w_ld  : '0;
   assign inc       = reset ? w_inc : '0;
   assign clr       = reset ? w_clr : c_RESET_CLR;
   assign x         = reset ? w_x   : '0;
   assign mem_read  = reset & w_rd;
   assign mem_write = reset & w_wr;
   assign alu_op    = reset ? w_alu : 2'b00;
   assign halted    = reset & ~r_s;
   assign sc        = reset ? 4'(r_sc) : 4'd0;

endmodule

`default_nettype wire
